// File: rtl/runner_game_ctrl.sv
// rtl/runner_game_ctrl.sv - segment-runner game core: FSM, tick generator, obstacles, collision, score
module runner_game_ctrl #(
    parameter int          LANES       = 6,
    parameter int          SCORE_W     = 14,
    parameter int          TICK_DIV    = 25000000,
    parameter int          TICK_MIN    = 5000000,
    parameter int          SPEED_STEP  = 1000000,
    parameter int          SPEED_SHIFT = 5,
    parameter int          LIVES       = 3,
    parameter int          HIT_TICKS   = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               LoggedIn,
    input  logic               GameButton,
    output logic [LANES-1:0]   FloorBits,
    output logic [LANES-1:0]   CeilingBits,
    output logic               PlayerPos,
    output logic               GameTick,
    output logic [3:0]         GameState,
    output logic [SCORE_W-1:0] GameScore,
    output logic [2:0]         LivesLeft
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int HW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam logic [SCORE_W-1:0] SPEED_MASK = SCORE_W'((64'd1 << SPEED_SHIFT) - 64'd1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_READY = 4'd1,
        ST_RUN   = 4'd2,
        ST_HIT   = 4'd3,
        ST_OVER  = 4'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [LANES-1:0]   floor_q,   floor_d;
    logic [LANES-1:0]   ceil_q,    ceil_d;
    logic               pos_q,     pos_d;
    logic               tick_q,    tick_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic [2:0]         lives_q,   lives_d;
    logic [15:0]        lfsr_q,    lfsr_d;
    logic [PW-1:0]      period_q,  period_d;
    logic [PW-1:0]      cnt_q,     cnt_d;
    logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
    logic               btn_q,     btn_d;

    logic               press;
    logic               running;
    logic               wrap;
    logic [15:0]        lfsr_adv;
    logic               prev_obs;
    logic               new_f;
    logic               new_c;
    logic [LANES-1:0]   floor_sh;
    logic [LANES-1:0]   ceil_sh;
    logic               pos_next;
    logic               hit_now;
    logic [SCORE_W-1:0] score_inc;
    logic               score_sat;
    logic [PW-1:0]      period_dec;

    assign FloorBits   = floor_q;
    assign CeilingBits = ceil_q;
    assign PlayerPos   = pos_q;
    assign GameTick    = tick_q;
    assign GameState   = state_q;
    assign GameScore   = score_q;
    assign LivesLeft   = lives_q;

    // Datapath helpers: press edge, tick wrap, next obstacle column, collision and speed-up values
    always_comb begin
        press    = GameButton & ~btn_q;
        running  = (state_q == ST_RUN) || (state_q == ST_HIT);
        wrap     = running && (cnt_q == period_q - PW'(1));

        // An all-zero LFSR would lock up, so it is reloaded with the seed instead of advancing.
        if (lfsr_q == 16'h0000) begin
            lfsr_adv = LFSR_SEED;
        end else begin
            lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        // The newest column sits at LANES-1; an obstacle there forces an empty column next.
        prev_obs = floor_q[LANES-1] | ceil_q[LANES-1];
        new_f    = 1'b0;
        new_c    = 1'b0;
        if (!prev_obs) begin
            case (lfsr_q[1:0])
                2'b10:   new_f = 1'b1;
                2'b11:   new_c = 1'b1;
                default: begin
                    new_f = 1'b0;
                    new_c = 1'b0;
                end
            endcase
        end
        floor_sh = {new_f, floor_q[LANES-1:1]};
        ceil_sh  = {new_c, ceil_q[LANES-1:1]};

        // A press landing on the tick edge moves the player before the collision test.
        pos_next = pos_q ^ press;
        hit_now  = pos_next ? ceil_sh[0] : floor_sh[0];

        score_inc = score_q + SCORE_W'(1);
        score_sat = &score_q;

        if (32'(period_q) >= 32'(TICK_MIN + SPEED_STEP)) begin
            period_dec = period_q - PW'(SPEED_STEP);
        end else begin
            period_dec = PW'(TICK_MIN);
        end
    end

    // Next-state logic for the game FSM and all registered outputs
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        ceil_d    = ceil_q;
        pos_d     = pos_q;
        tick_d    = 1'b0;
        score_d   = score_q;
        lives_d   = lives_q;
        lfsr_d    = lfsr_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        hit_cnt_d = hit_cnt_q;
        btn_d     = GameButton;

        // The tick counter only runs while a game is in play; OVER holds it.
        if (running) begin
            cnt_d = wrap ? '0 : cnt_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (LoggedIn) begin
                    state_d  = ST_READY;
                    floor_d  = '0;
                    ceil_d   = '0;
                    score_d  = '0;
                    lives_d  = 3'(LIVES);
                    period_d = PW'(TICK_DIV);
                    pos_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_READY: begin
                if (press) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                pos_d = pos_next;
                if (wrap) begin
                    tick_d  = 1'b1;
                    floor_d = floor_sh;
                    ceil_d  = ceil_sh;
                    lfsr_d  = lfsr_adv;
                    if (hit_now) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d    = ST_HIT;
                            hit_cnt_d  = '0;
                            floor_d[0] = 1'b0;
                            ceil_d[0]  = 1'b0;
                        end
                    end else if (!score_sat) begin
                        score_d = score_inc;
                        if ((score_inc & SPEED_MASK) == '0) begin
                            period_d = period_dec;
                        end
                    end
                end
            end
            ST_HIT: begin
                if (wrap) begin
                    tick_d = 1'b1;
                    if (hit_cnt_q == HW'(HIT_TICKS - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        hit_cnt_d = hit_cnt_q + HW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (press) begin
                    state_d  = ST_READY;
                    floor_d  = '0;
                    ceil_d   = '0;
                    score_d  = '0;
                    lives_d  = 3'(LIVES);
                    period_d = PW'(TICK_DIV);
                    pos_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Logout overrides everything, including a tick landing on the same edge.
        if (!LoggedIn) begin
            state_d   = ST_IDLE;
            floor_d   = '0;
            ceil_d    = '0;
            score_d   = '0;
            lives_d   = '0;
            pos_d     = 1'b0;
            tick_d    = 1'b0;
            lfsr_d    = lfsr_q;
            period_d  = PW'(TICK_DIV);
            cnt_d     = '0;
            hit_cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            ceil_q    <= '0;
            pos_q     <= 1'b0;
            tick_q    <= 1'b0;
            score_q   <= '0;
            lives_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            period_q  <= PW'(TICK_DIV);
            cnt_q     <= '0;
            hit_cnt_q <= '0;
            btn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            ceil_q    <= ceil_d;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            lfsr_q    <= lfsr_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            hit_cnt_q <= hit_cnt_d;
            btn_q     <= btn_d;
        end
    end

endmodule

// File: tb/tb_runner_game_ctrl.sv
// tb/tb_runner_game_ctrl.sv - directed bench for runner_game_ctrl
module tb_runner_game_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        LoggedIn = 1'b0;
    logic        GameButton = 1'b0;
    logic [5:0]  FloorBits;
    logic [5:0]  CeilingBits;
    logic        PlayerPos;
    logic        GameTick;
    logic [3:0]  GameState;
    logic [13:0] GameScore;
    logic [2:0]  LivesLeft;

    int total = 0;
    int bad = 0;

    runner_game_ctrl #(
        .LANES(6), .SCORE_W(14), .TICK_DIV(4), .TICK_MIN(2), .SPEED_STEP(1),
        .SPEED_SHIFT(2), .LIVES(2), .HIT_TICKS(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .LoggedIn(LoggedIn), .GameButton(GameButton),
        .FloorBits(FloorBits), .CeilingBits(CeilingBits), .PlayerPos(PlayerPos),
        .GameTick(GameTick), .GameState(GameState), .GameScore(GameScore),
        .LivesLeft(LivesLeft)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press();
        @(negedge Clk) GameButton = 1'b1;
        @(negedge Clk) GameButton = 1'b0;
    endtask

    // Returns the number of falling edges until GameTick is seen high.
    task automatic wait_tick(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            n++;
            if (GameTick) return;
        end
        total++;
        bad++;
        $display("FAIL tick_timeout waited=%0d", n);
        n = 0;
    endtask

    int n;
    int exp_sp;
    int ticks;
    int viol_ov;
    int viol_gap;
    int seen_obs;
    int tick_cnt;
    logic [5:0] occ;

    initial begin
        force dut.lfsr_q = 16'h0000;

        // Reset values
        repeat (3) @(negedge Clk);
        chk("rst_state", 32'(GameState), 32'd0);
        chk("rst_floor", 32'(FloorBits), 32'd0);
        chk("rst_ceil", 32'(CeilingBits), 32'd0);
        chk("rst_pos", 32'(PlayerPos), 32'd0);
        chk("rst_tick", 32'(GameTick), 32'd0);
        chk("rst_score", 32'(GameScore), 32'd0);
        chk("rst_lives", 32'(LivesLeft), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("idle_hold", 32'(GameState), 32'd0);

        // Login and start
        LoggedIn = 1'b1;
        @(negedge Clk);
        chk("ready_state", 32'(GameState), 32'd1);
        chk("ready_lives", 32'(LivesLeft), 32'd2);
        press();
        chk("run_state", 32'(GameState), 32'd2);
        wait_tick(n);
        chk("first_tick_lat", 32'(n), 32'd4);
        chk("score_1", 32'(GameScore), 32'd1);

        // Scoring and speed-up with empty columns
        for (int i = 2; i <= 14; i++) begin
            wait_tick(n);
            exp_sp = (i <= 4) ? 4 : ((i <= 8) ? 3 : 2);
            chk($sformatf("spacing_t%0d", i), 32'(n), 32'(exp_sp));
            if (i == 4) chk("score_4", 32'(GameScore), 32'd4);
        end
        chk("score_14", 32'(GameScore), 32'd14);

        // Collision: one floor obstacle travels to the player column
        force dut.lfsr_q = 16'h0002;
        wait_tick(n);
        chk("floor_insert", 32'(FloorBits), 32'h20);
        force dut.lfsr_q = 16'h0000;
        repeat (4) wait_tick(n);
        chk("floor_bit1", 32'(FloorBits), 32'h02);
        chk("score_19", 32'(GameScore), 32'd19);
        wait_tick(n);
        chk("hit_state", 32'(GameState), 32'd3);
        chk("hit_lives", 32'(LivesLeft), 32'd1);
        chk("hit_floor_clr", 32'(FloorBits), 32'h00);
        chk("hit_score", 32'(GameScore), 32'd19);
        wait_tick(n);
        chk("hit_hold", 32'(GameState), 32'd3);
        wait_tick(n);
        chk("hit_resume", 32'(GameState), 32'd2);
        chk("hit_resume_score", 32'(GameScore), 32'd19);

        // Dodge: press on the tick edge that brings a floor obstacle to bit 0
        force dut.lfsr_q = 16'h0002;
        wait_tick(n);
        force dut.lfsr_q = 16'h0000;
        repeat (4) wait_tick(n);
        chk("dodge_pre_floor", 32'(FloorBits), 32'h02);
        @(negedge Clk) GameButton = 1'b1;
        @(negedge Clk) GameButton = 1'b0;
        chk("dodge_tick", 32'(GameTick), 32'd1);
        chk("dodge_pos", 32'(PlayerPos), 32'd1);
        chk("dodge_state", 32'(GameState), 32'd2);
        chk("dodge_score", 32'(GameScore), 32'd25);
        chk("dodge_floor", 32'(FloorBits), 32'h01);
        chk("dodge_lives", 32'(LivesLeft), 32'd1);

        // Second hit on the ceiling row ends the game
        force dut.lfsr_q = 16'h0003;
        wait_tick(n);
        chk("ceil_insert", 32'(CeilingBits), 32'h20);
        force dut.lfsr_q = 16'h0000;
        repeat (4) wait_tick(n);
        chk("ceil_bit1", 32'(CeilingBits), 32'h02);
        wait_tick(n);
        chk("over_state", 32'(GameState), 32'd4);
        chk("over_lives", 32'(LivesLeft), 32'd0);
        chk("over_score", 32'(GameScore), 32'd30);
        tick_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (GameTick) tick_cnt++;
        end
        chk("over_no_tick", 32'(tick_cnt), 32'd0);
        chk("over_score_frozen", 32'(GameScore), 32'd30);

        // Restart with a button held high for ten cycles
        @(negedge Clk) GameButton = 1'b1;
        repeat (10) @(negedge Clk);
        GameButton = 1'b0;
        chk("restart_state", 32'(GameState), 32'd1);
        chk("restart_score", 32'(GameScore), 32'd0);
        chk("restart_lives", 32'(LivesLeft), 32'd2);
        chk("restart_pos", 32'(PlayerPos), 32'd0);
        chk("restart_floor", 32'(FloorBits | CeilingBits), 32'd0);

        // Free-running obstacle invariants over 1000 ticks, restarting after each game over
        release dut.lfsr_q;
        ticks = 0;
        viol_ov = 0;
        viol_gap = 0;
        seen_obs = 0;
        for (int k = 0; k < 20000 && ticks < 1000; k++) begin
            @(negedge Clk);
            occ = FloorBits | CeilingBits;
            if ((FloorBits & CeilingBits) != 6'd0) viol_ov++;
            if ((occ & (occ >> 1)) != 6'd0) viol_gap++;
            if (occ != 6'd0) seen_obs = 1;
            if (GameTick) ticks++;
            if ((GameState == 4'd1 || GameState == 4'd4) && !GameButton) GameButton = 1'b1;
            else GameButton = 1'b0;
        end
        chk("inv_ticks", 32'(ticks >= 1000), 32'd1);
        chk("inv_overlap", 32'(viol_ov), 32'd0);
        chk("inv_gap", 32'(viol_gap), 32'd0);
        chk("inv_obstacles_seen", 32'(seen_obs), 32'd1);

        // Logout while running
        for (int k = 0; k < 200 && GameState != 4'd2; k++) begin
            @(negedge Clk);
            if ((GameState == 4'd1 || GameState == 4'd4) && !GameButton) GameButton = 1'b1;
            else GameButton = 1'b0;
        end
        GameButton = 1'b0;
        chk("pre_logout_run", 32'(GameState), 32'd2);
        LoggedIn = 1'b0;
        @(negedge Clk);
        chk("logout_state", 32'(GameState), 32'd0);
        chk("logout_bitmaps", 32'(FloorBits | CeilingBits), 32'd0);
        chk("logout_score", 32'(GameScore), 32'd0);
        chk("logout_lives", 32'(LivesLeft), 32'd0);
        chk("logout_pos", 32'(PlayerPos), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
